// File: rtl/nand_logic_pkg.sv
// Shared constants for the NAND logic pipeline:
// op encodings and default parameter values.
package nand_logic_pkg;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/nand_op_core.sv
// Combinational WIDTH-bit op evaluator built from 2-input NAND terms.
// Ports: a, b (operands), op (select), r (result).
module nand_op_core
    import nand_logic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] nab;
    logic [WIDTH-1:0] naa;
    logic [WIDTH-1:0] nbb;
    logic [WIDTH-1:0] and_t;
    logic [WIDTH-1:0] or_t;
    logic [WIDTH-1:0] nor_t;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] xor_t;
    logic [WIDTH-1:0] xnor_t;
    logic [WIDTH-1:0] pass_t;

    assign nab    = ~(a & b);
    assign naa    = ~(a & a);
    assign nbb    = ~(b & b);
    assign and_t  = ~(nab & nab);
    assign or_t   = ~(naa & nbb);
    assign nor_t  = ~(or_t & or_t);
    // Classic four-gate XOR sharing the a/b NAND term.
    assign x1     = ~(a & nab);
    assign x2     = ~(b & nab);
    assign xor_t  = ~(x1 & x2);
    assign xnor_t = ~(xor_t & xor_t);
    assign pass_t = ~(naa & naa);

    always_comb begin
        r = '0;
        unique case (op)
            OP_NAND: r = nab;
            OP_AND:  r = and_t;
            OP_OR:   r = or_t;
            OP_NOR:  r = nor_t;
            OP_XOR:  r = xor_t;
            OP_XNOR: r = xnor_t;
            OP_NOTA: r = naa;
            OP_PASS: r = pass_t;
            default: r = nab;
        endcase
    end

endmodule

// File: rtl/nand_logic_pipe.sv
// Pipelined NAND logic unit with valid/ready handshake and
// a saturating delivered-result counter.
// Ports: clk, rst (sync, active-high), in_valid/in_ready,
// a, b, op, out_valid/out_ready, y, zero, op_count,
// y_par (only when NAND_LOGIC_PIPE_PARITY_EN is defined).
module nand_logic_pipe
    import nand_logic_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
`ifdef NAND_LOGIC_PIPE_PARITY_EN
    output logic             y_par,
`endif
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r;
    logic             adv;
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [CNT_W-1:0]  cnt;

    nand_op_core #(.WIDTH(WIDTH)) u_core (
        .a  (a),
        .b  (b),
        .op (op),
        .r  (r)
    );

    // Whole pipe moves in lockstep; bubbles are kept, not squeezed.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= '0;
        end else if (adv) begin
            v[0] <= in_valid;
            d[0] <= r;
            for (int i = 1; i < STAGES; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end

`ifdef NAND_LOGIC_PIPE_PARITY_EN
    logic [STAGES-1:0] p;

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (adv) begin
            p[0] <= ^r;
            for (int i = 1; i < STAGES; i++) p[i] <= p[i-1];
        end
    end

    assign y_par = p[STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (out_valid && out_ready && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign out_valid = v[STAGES-1];
    assign y         = d[STAGES-1];
    assign zero      = out_valid & ~(|y);
    assign op_count  = cnt;

endmodule
